cnn_layer_sequencer: RTL and testbench

//  Parametrised control core for the CNN top. Chains N_LAYERS layers via start/end pulses and overlaps frames

---
 rtl/cnn_layer_sequencer.sv | 160 ++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sequencer.sv
// rtl/cnn_layer_sequencer.sv - layer chaining control, per-layer watchdog and sequential argmax over class scores
module cnn_layer_sequencer #(
    parameter int N_LAYERS    = 5,
    parameter int N_CLASSES   = 10,
    parameter int OUT_W       = 15,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 50000,
    parameter int PIPELINED   = 1,
    localparam int CLS_W      = $clog2(N_CLASSES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_flag,
    output logic                         in_ready,
    output logic [N_LAYERS-1:0]          layer_start,
    input  logic [N_LAYERS-1:0]          layer_end,
    input  logic [N_CLASSES*OUT_W-1:0]   scores,
    output logic [CLS_W-1:0]             class_id,
    output logic [OUT_W-1:0]             max_score,
    output logic                         end_flag,
    output logic                         busy,
    output logic                         timeout_err,
    output logic [15:0]                  frame_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CLS_W-1:0]     LAST_IDX = CLS_W'(N_CLASSES - 1);
    localparam logic [TIMEOUT_W-1:0] WD_LAST  = TIMEOUT_W'(TIMEOUT_CYC - 1);

    logic [N_LAYERS-1:0]     pend;
    logic [N_LAYERS-1:0]     occ;
    logic [N_LAYERS-1:0]     arrive;
    logic [N_LAYERS-1:0]     dfree;
    logic [N_LAYERS-1:0]     go;
    logic [TIMEOUT_W-1:0]    wd_cnt [N_LAYERS];
    logic                    wd_hit;

    logic [1:0]              state;
    logic                    scan_busy;
    logic                    last_arrive;
    logic signed [OUT_W-1:0] score_q [N_CLASSES];
    logic signed [OUT_W-1:0] best;
    logic [CLS_W-1:0]        best_idx;
    logic [CLS_W-1:0]        scan_idx;
    logic signed [OUT_W-1:0] nxt_best;
    logic [CLS_W-1:0]        nxt_idx;

    assign scan_busy   = (state != S_IDLE);
    assign busy        = (|pend) | (|occ) | scan_busy;
    assign in_ready    = (PIPELINED != 0) ? (!pend[0] && !occ[0] && !timeout_err)
                                          : (!busy && !timeout_err);
    assign last_arrive = layer_end[N_LAYERS-1] & occ[N_LAYERS-1];

    // A stage only issues when its downstream neighbour is empty, so its outputs stay put while consumed.
    always_comb begin
        arrive    = '0;
        dfree     = '0;
        go        = '0;
        arrive[0] = start_flag & in_ready;
        for (int i = 1; i < N_LAYERS; i++) begin
            arrive[i] = layer_end[i-1] & occ[i-1];
        end
        for (int i = 0; i < N_LAYERS - 1; i++) begin
            dfree[i] = !occ[i+1] & !pend[i+1];
        end
        dfree[N_LAYERS-1] = !scan_busy;
        for (int i = 0; i < N_LAYERS; i++) begin
            go[i] = (pend[i] | arrive[i]) & !occ[i] & dfree[i] & !timeout_err;
        end
    end

    always_comb begin
        wd_hit = 1'b0;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (TIMEOUT_CYC != 0 && occ[i] && wd_cnt[i] == WD_LAST) begin
                wd_hit = 1'b1;
            end
        end
    end

    // Strictly greater keeps the lowest index on ties.
    always_comb begin
        nxt_best = best;
        nxt_idx  = best_idx;
        if (score_q[scan_idx] > best) begin
            nxt_best = score_q[scan_idx];
            nxt_idx  = scan_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend        <= '0;
            occ         <= '0;
            layer_start <= '0;
            timeout_err <= 1'b0;
            state       <= S_IDLE;
            best        <= '0;
            best_idx    <= '0;
            scan_idx    <= '0;
            class_id    <= '0;
            max_score   <= '0;
            end_flag    <= 1'b0;
            frame_cnt   <= '0;
            for (int i = 0; i < N_LAYERS; i++) begin
                wd_cnt[i] <= '0;
            end
            for (int k = 0; k < N_CLASSES; k++) begin
                score_q[k] <= '0;
            end
        end else begin
            layer_start <= go;
            occ         <= go | (occ & ~layer_end);
            pend        <= (pend | arrive) & ~go;
            for (int i = 0; i < N_LAYERS; i++) begin
                if (go[i]) begin
                    wd_cnt[i] <= '0;
                end else if (occ[i]) begin
                    wd_cnt[i] <= wd_cnt[i] + TIMEOUT_W'(1);
                end
            end
            if (wd_hit) begin
                timeout_err <= 1'b1;
            end
            end_flag <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (last_arrive && !timeout_err) begin
                        for (int k = 0; k < N_CLASSES; k++) begin
                            score_q[k] <= scores[k*OUT_W +: OUT_W];
                        end
                        best     <= scores[0 +: OUT_W];
                        best_idx <= '0;
                        scan_idx <= CLS_W'(1);
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (scan_idx == LAST_IDX) begin
                        class_id  <= nxt_idx;
                        max_score <= nxt_best;
                        end_flag  <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= S_DONE;
                    end else begin
                        best     <= nxt_best;
                        best_idx <= nxt_idx;
                        scan_idx <= scan_idx + CLS_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb/tb_cnn_layer_sequencer.sv - scoreboard bench for cnn_layer_sequencer with stub layers
module tb_cnn_layer_sequencer;

    typedef struct {
        int cls;
        int score;
        int fcnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   start_flag = '0;
    logic [1:0]   in_ready;
    logic [4:0]   ls [2];
    logic [4:0]   le [2];
    logic [149:0] scores = '0;
    logic [3:0]   cls [2];
    logic [14:0]  msc [2];
    logic [1:0]   end_flag;
    logic [1:0]   busy;
    logic [1:0]   to_err;
    logic [15:0]  fcnt [2];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat [5];
    int stub_cnt [2][5];
    int ls_cnt [2][5];
    int ls_cyc [2][5];
    int le_cyc [2][5];
    int end_cnt [2];
    int to_seen [2];
    int to_cyc [2];
    int exp_fcnt [2];
    int st_cyc;
    exp_t q0 [$];
    exp_t q1 [$];

    cnn_layer_sequencer #(.N_LAYERS(5), .N_CLASSES(10), .OUT_W(15), .TIMEOUT_W(16),
                          .TIMEOUT_CYC(100), .PIPELINED(1)) dut_p (
        .clk(clk), .reset(reset), .start_flag(start_flag[0]), .in_ready(in_ready[0]),
        .layer_start(ls[0]), .layer_end(le[0]), .scores(scores), .class_id(cls[0]),
        .max_score(msc[0]), .end_flag(end_flag[0]), .busy(busy[0]), .timeout_err(to_err[0]),
        .frame_cnt(fcnt[0])
    );

    cnn_layer_sequencer #(.N_LAYERS(5), .N_CLASSES(10), .OUT_W(15), .TIMEOUT_W(16),
                          .TIMEOUT_CYC(100), .PIPELINED(0)) dut_s (
        .clk(clk), .reset(reset), .start_flag(start_flag[1]), .in_ready(in_ready[1]),
        .layer_start(ls[1]), .layer_end(le[1]), .scores(scores), .class_id(cls[1]),
        .max_score(msc[1]), .end_flag(end_flag[1]), .busy(busy[1]), .timeout_err(to_err[1]),
        .frame_cnt(fcnt[1])
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stub layers: layer_end pulses lat[i] cycles after the layer_start seen; lat 0 never ends.
    initial begin
        le[0] = '0;
        le[1] = '0;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 5; i++) stub_cnt[d][i] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 5; i++) begin
                    logic v;
                    v = 1'b0;
                    if (stub_cnt[d][i] > 0) begin
                        stub_cnt[d][i] = stub_cnt[d][i] - 1;
                        if (stub_cnt[d][i] == 0) v = 1'b1;
                    end
                    if (ls[d][i]) stub_cnt[d][i] = lat[i];
                    le[d][i] = v;
                    if (v) le_cyc[d][i] = cyc;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every end_flag.
    initial begin
        for (int d = 0; d < 2; d++) begin
            end_cnt[d] = 0;
            to_seen[d] = 0;
            for (int i = 0; i < 5; i++) begin
                ls_cnt[d][i] = 0;
                ls_cyc[d][i] = -1;
                le_cyc[d][i] = -1;
            end
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 5; i++) begin
                    if (ls[d][i]) begin
                        ls_cnt[d][i] = ls_cnt[d][i] + 1;
                        ls_cyc[d][i] = cyc;
                    end
                end
                if (to_err[d] && to_seen[d] == 0) begin
                    to_seen[d] = 1;
                    to_cyc[d] = cyc;
                end
                if (end_flag[d]) begin
                    exp_t e;
                    end_cnt[d] = end_cnt[d] + 1;
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        chk("unexpected_end_flag", 1, 0);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk("class_id", cls[d], e.cls);
                        chk("max_score", msc[d], e.score);
                        chk("frame_cnt", fcnt[d], e.fcnt);
                        chk("end_latency", cyc, le_cyc[d][4] + 10);
                    end
                end
            end
        end
    end

    task automatic expect_frame(input int d, input int c, input int s);
        exp_t e;
        exp_fcnt[d] = exp_fcnt[d] + 1;
        e.cls = c;
        e.score = s & 32'h7fff;
        e.fcnt = exp_fcnt[d];
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic set_scores(input int v [10]);
        for (int k = 0; k < 10; k++) scores[k*15 +: 15] = 15'(v[k]);
    endtask

    task automatic start_frame(input int d);
        @(negedge clk);
        start_flag[d] = 1'b1;
        st_cyc = cyc;
        @(negedge clk);
        start_flag[d] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        q0.delete();
        q1.delete();
        exp_fcnt[0] = 0;
        exp_fcnt[1] = 0;
        to_seen[0] = 0;
        to_seen[1] = 0;
    endtask

    task automatic wait_end(input int d, input int n, input int budget);
        int k = 0;
        while (end_cnt[d] < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("end_flag_arrived", end_cnt[d] >= n, 1);
    endtask

    task automatic wait_ls(input int d, input int i, input int n, input int budget);
        int k = 0;
        while (ls_cnt[d][i] < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("layer_start_seen", ls_cnt[d][i] >= n, 1);
    endtask

    initial begin
        int sv [10];
        int base;
        int e1;
        lat = '{3, 2, 4, 1, 2};
        exp_fcnt = '{0, 0};

        repeat (3) @(negedge clk);
        chk("rst_layer_start", ls[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_end_flag", end_flag[0], 0);
        chk("rst_timeout", to_err[0], 0);
        chk("rst_frame_cnt", fcnt[0], 0);
        chk("rst_class_id", cls[0], 0);
        chk("rst_max_score", msc[0], 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready[0], 1);

        // Test 1: single frame through five layers, per-stage latency
        sv = '{-10, 5, 99, -100, 0, 42, -1, 100, 99, 7};
        set_scores(sv);
        expect_frame(0, 7, 100);
        start_frame(0);
        wait_end(0, 1, 100);
        chk("t1_start0_lat", ls_cyc[0][0], st_cyc + 1);
        for (int i = 1; i < 5; i++) chk("t1_start_lat", ls_cyc[0][i], le_cyc[0][i-1] + 1);
        @(negedge clk);
        chk("t1_busy_after", busy[0], 0);

        // Test 2: tie keeps lowest index, all-minimum scores
        sv = '{-5, -5, -5, 20, -5, -5, -5, -5, 20, -5};
        set_scores(sv);
        expect_frame(0, 3, 20);
        start_frame(0);
        wait_end(0, 2, 100);
        sv = '{-16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384};
        set_scores(sv);
        expect_frame(0, 0, 32'h4000);
        start_frame(0);
        wait_end(0, 3, 100);

        // Test 3: overlapping frames, slow layer 1
        do_reset();
        lat = '{2, 20, 2, 2, 2};
        sv = '{-10, 5, 99, -100, 0, 42, -1, 100, 99, 7};
        set_scores(sv);
        base = end_cnt[0];
        e1 = ls_cnt[0][0];
        expect_frame(0, 7, 100);
        expect_frame(0, 7, 100);
        start_frame(0);
        repeat (3) @(negedge clk);
        chk("t3_in_ready_second", in_ready[0], 1);
        start_frame(0);
        wait_ls(0, 0, e1 + 2, 100);
        chk("t3_frame2_start0", ls_cyc[0][0], le_cyc[0][1] + 2);
        wait_end(0, base + 2, 200);
        chk("t3_frame_cnt", fcnt[0], 2);

        // Test 4: non-pipelined core drops a request while busy
        do_reset();
        lat = '{2, 2, 2, 2, 2};
        base = end_cnt[1];
        e1 = ls_cnt[1][0];
        expect_frame(1, 7, 100);
        start_frame(1);
        repeat (4) @(negedge clk);
        chk("t4_in_ready_busy", in_ready[1], 0);
        chk("t4_busy", busy[1], 1);
        start_frame(1);
        wait_end(1, base + 1, 100);
        repeat (40) @(posedge clk);
        chk("t4_one_end_flag", end_cnt[1] - base, 1);
        chk("t4_one_start", ls_cnt[1][0] - e1, 1);
        chk("t4_frame_cnt", fcnt[1], 1);
        @(negedge clk);
        chk("t4_in_ready_idle", in_ready[1], 1);

        // Test 5: watchdog on a layer that never ends
        do_reset();
        lat = '{2, 2, 0, 2, 2};
        e1 = ls_cnt[0][2];
        start_frame(0);
        wait_ls(0, 2, e1 + 1, 50);
        begin
            int k = 0;
            while (to_seen[0] == 0 && k < 300) begin
                @(posedge clk);
                k++;
            end
        end
        chk("t5_timeout_seen", to_seen[0], 1);
        chk("t5_timeout_cycle", to_cyc[0], ls_cyc[0][2] + 100);
        @(negedge clk);
        chk("t5_in_ready", in_ready[0], 0);
        e1 = ls_cnt[0][0];
        start_frame(0);
        repeat (20) @(posedge clk);
        chk("t5_start_ignored", ls_cnt[0][0], e1);
        do_reset();
        chk("t5_reset_timeout", to_err[0], 0);
        chk("t5_reset_busy", busy[0], 0);
        chk("t5_reset_in_ready", in_ready[0], 1);

        // Test 6: reset while layer 3 runs, stray layer_end afterwards
        lat = '{2, 2, 2, 6, 2};
        e1 = ls_cnt[0][3];
        start_frame(0);
        wait_ls(0, 3, e1 + 1, 50);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = end_cnt[0];
        e1 = ls_cnt[0][4];
        repeat (30) @(posedge clk);
        chk("t6_stray_end_seen", le_cyc[0][3], ls_cyc[0][3] + 6);
        chk("t6_no_start4", ls_cnt[0][4], e1);
        chk("t6_no_end_flag", end_cnt[0], base);
        @(negedge clk);
        chk("t6_busy", busy[0], 0);
        chk("t6_layer_start", ls[0], 0);
        chk("t6_class_id", cls[0], 0);
        chk("t6_max_score", msc[0], 0);
        chk("t6_frame_cnt", fcnt[0], 0);
        chk("t6_queue_empty", q0.size() + q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
